// File: rtl/my_interface.sv
// Registered master-to-slave link with a reader stage that captures data and
// valid-qualified addresses and counts accepted transfers.
module my_interface #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_data,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic              set_data_en,
  input  logic              set_data_val,
  output logic              s_data,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic              cap_data,
  output logic [ADDR_W-1:0] cap_addr,
  output logic [7:0]        xfer_cnt
);

  logic next_s_data;

  // The override strobe wins over master data and touches only the data bit.
  always_comb begin
    next_s_data = m_data;
    if (set_data_en) begin
      next_s_data = set_data_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_data  <= 1'b0;
      s_valid <= 1'b0;
      s_addr  <= '0;
    end else begin
      s_data  <= next_s_data;
      s_valid <= m_valid;
      s_addr  <= m_addr;
    end
  end

  // Reader stage: data always follows the slave side, address and count only on valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_data <= 1'b0;
      cap_addr <= '0;
      xfer_cnt <= 8'd0;
    end else begin
      cap_data <= s_data;
      if (s_valid) begin
        cap_addr <= s_addr;
        xfer_cnt <= xfer_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_my_interface.sv
// Directed self-checking bench for my_interface: reset, pipeline, override,
// valid gating, async mid-stream reset and counter wrap.
module tb_my_interface;

  logic       clk;
  logic       rst_n;
  logic       m_data;
  logic       m_valid;
  logic [7:0] m_addr;
  logic       set_data_en;
  logic       set_data_val;
  logic       s_data;
  logic       s_valid;
  logic [7:0] s_addr;
  logic       cap_data;
  logic [7:0] cap_addr;
  logic [7:0] xfer_cnt;

  int errors = 0;
  int checks = 0;

  my_interface #(.ADDR_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_addr       (m_addr),
    .set_data_en  (set_data_en),
    .set_data_val (set_data_val),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_addr       (s_addr),
    .cap_data     (cap_data),
    .cap_addr     (cap_addr),
    .xfer_cnt     (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] addr, input logic data,
                               input logic sen, input logic sval);
    m_valid      = valid;
    m_addr       = addr;
    m_data       = data;
    set_data_en  = sen;
    set_data_val = sval;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".s_data"},   32'(s_data),   32'h0);
    checkOutput({tag, ".s_valid"},  32'(s_valid),  32'h0);
    checkOutput({tag, ".s_addr"},   32'(s_addr),   32'h0);
    checkOutput({tag, ".cap_data"}, 32'(cap_data), 32'h0);
    checkOutput({tag, ".cap_addr"}, 32'(cap_addr), 32'h0);
    checkOutput({tag, ".xfer_cnt"}, 32'(xfer_cnt), 32'h0);
  endtask

  initial begin
    logic [7:0] bit_pat;
    bit_pat = 8'b0101_0101;

    // Reset held with busy inputs and an active override strobe.
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
    #2;
    checkAllZero("reset_imm");
    repeat (3) tick();
    checkAllZero("reset_clk");

    // Release between edges with quiet inputs.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst.s_data", 32'(s_data), 32'h0);

    // Alternating data: s_data one edge behind, cap_data two edges behind.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 8'h00, bit_pat[i], 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("pipe%0d.s_data", i), 32'(s_data), 32'(bit_pat[i]));
      if (i > 0)
        checkOutput($sformatf("pipe%0d.cap_data", i), 32'(cap_data), 32'(bit_pat[i-1]));
    end

    // Override high for one cycle against m_data=0.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("ovr_hi.s_data", 32'(s_data), 32'h1);
    checkOutput("ovr_hi.s_valid", 32'(s_valid), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("ovr_end.s_data", 32'(s_data), 32'h0);
    checkOutput("ovr_end.cap_data", 32'(cap_data), 32'h1);

    // Override low against m_data=1, address path untouched.
    applyStimulus(1'b0, 8'h3C, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("ovr_lo.s_data", 32'(s_data), 32'h0);
    checkOutput("ovr_lo.s_addr", 32'(s_addr), 32'h3C);

    // Valid gating: 35 captured, AA never captured.
    applyStimulus(1'b1, 8'h35, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("vg1.s_valid", 32'(s_valid), 32'h1);
    checkOutput("vg1.s_addr", 32'(s_addr), 32'h35);
    checkOutput("vg1.cap_addr", 32'(cap_addr), 32'h00);
    applyStimulus(1'b0, 8'hAA, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("vg2.s_addr", 32'(s_addr), 32'hAA);
    checkOutput("vg2.cap_addr", 32'(cap_addr), 32'h35);
    checkOutput("vg2.xfer_cnt", 32'(xfer_cnt), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("vg_hold%0d.cap_addr", i), 32'(cap_addr), 32'h35);
    end
    checkOutput("vg_hold.xfer_cnt", 32'(xfer_cnt), 32'h1);

    // Async reset between edges while the link is busy.
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("busy.cap_addr", 32'(cap_addr), 32'h5A);
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1);
    #2;
    checkAllZero("async_rst");
    tick();
    checkOutput("rst_ovr.s_data", 32'(s_data), 32'h0);

    // Release and hold valid to walk the counter through its wrap.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("rel.s_valid", 32'(s_valid), 32'h1);
    checkOutput("rel.s_addr", 32'(s_addr), 32'h11);
    checkOutput("rel.s_data", 32'(s_data), 32'h0);
    checkOutput("rel.xfer_cnt", 32'(xfer_cnt), 32'h0);
    for (int k = 2; k <= 258; k++) begin
      tick();
      if (k == 128) checkOutput("wrap_mid.xfer_cnt", 32'(xfer_cnt), 32'd127);
      if (k == 256) checkOutput("wrap_255.xfer_cnt", 32'(xfer_cnt), 32'd255);
      if (k == 257) checkOutput("wrap_0.xfer_cnt", 32'(xfer_cnt), 32'd0);
      if (k == 258) checkOutput("wrap_1.xfer_cnt", 32'(xfer_cnt), 32'd1);
    end
    checkOutput("wrap.cap_addr", 32'(cap_addr), 32'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/my_interface.md
MY_INTERFACE -- requirements
Module: my_interface

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the address width of the link.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port m_data, input, 1 bit: master-side data.
REQ-005 SHALL have port m_valid, input, 1 bit: master-side valid qualifier.
REQ-006 SHALL have port m_addr, input, ADDR_W bits: master-side address.
REQ-007 SHALL have port set_data_en, input, 1 bit: one-cycle data-override strobe (set_data method).
REQ-008 SHALL have port set_data_val, input, 1 bit: override value, used when set_data_en=1.
REQ-009 SHALL have port s_data, output, 1 bit: slave-side registered data.
REQ-010 SHALL have port s_valid, output, 1 bit: slave-side registered valid.
REQ-011 SHALL have port s_addr, output, ADDR_W bits: slave-side registered address.
REQ-012 SHALL have port cap_data, output, 1 bit: reader-captured data.
REQ-013 SHALL have port cap_addr, output, ADDR_W bits: reader-captured address, updated only on valid.
REQ-014 SHALL have port xfer_cnt, output, 8 bits: count of cycles with s_valid=1.

Function
REQ-015 Each rising clk edge SHALL load s_valid with m_valid and s_addr with m_addr (1-cycle latency).
REQ-016 Each rising clk edge SHALL load s_data with the following value:
- set_data_val when set_data_en=1;
- m_data otherwise.
REQ-017 The set_data override SHALL take priority over m_data in the same cycle and SHALL affect s_data only, not s_valid or s_addr.
REQ-018 Each rising clk edge SHALL load cap_data with the current s_data, so cap_data lags m_data by 2 cycles.
REQ-019 Each rising clk edge SHALL load cap_addr with s_addr when s_valid=1, and SHALL hold cap_addr when s_valid=0.
REQ-020 Each rising clk edge SHALL increment xfer_cnt by 1 when s_valid=1, wrapping modulo 256 (255 -> 0), with no saturation or flag.
REQ-021 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-022 No handshake/backpressure: the slave side SHALL accept every cycle unconditionally.

Reset
REQ-023 While rst_n=0, the following outputs SHALL be forced to 0 immediately, independent of clk:
- s_data, s_valid, s_addr;
- cap_data, cap_addr;
- xfer_cnt.
REQ-024 Reset asserted mid-stream SHALL discard in-flight values; after release, the first rising edge SHALL load from the inputs as in REQ-015/016.
REQ-025 set_data_en asserted while rst_n=0 SHALL have no effect.

Verification
REQ-026 Reset: drive rst_n=0 with m_valid=1, m_addr=8'hFF, then toggle clk -> all outputs remain 0.
REQ-027 Pipeline: m_data alternating 0,1,0,1 each cycle -> s_data follows 1 cycle later and cap_data 2 cycles later.
REQ-028 Override: m_data=0, set_data_en=1, set_data_val=1 for one cycle -> s_data=1 for exactly that cycle, then 0.
REQ-029 Valid gating, cycle sequence:
- cycle 1: m_valid=1, m_addr=8'h35;
- cycle 2: m_valid=0, m_addr=8'hAA;
- result: cap_addr=8'h35 from cycle 3 onward and never 8'hAA.
REQ-030 Counter wrap: hold m_valid=1 for 257 cycles -> xfer_cnt goes 255 -> 0 -> 1.
REQ-031 Async reset mid-stream: assert rst_n=0 between clock edges -> outputs go 0 before the next edge.
